// File: rtl/spi_pkg.sv
// Shared definitions for the SPI command front end and the RAM behind it.
package spi_pkg;

    localparam int FRAME_W = 10;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

endpackage

// File: rtl/spi_shift_out.sv
// Parallel-load MSB-first serializer; the first bit appears on the edge that loads.
module spi_shift_out #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] data,
    output logic         serial,
    output logic         done
);
    localparam int CW = $clog2(W) + 1;

    logic [W-1:0]  sreg;
    logic [CW-1:0] cnt;
    logic          busy;

    assign done = !busy;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            sreg   <= '0;
            cnt    <= '0;
            serial <= 1'b0;
            busy   <= 1'b0;
        end else if (load) begin
            serial <= data[W-1];
            sreg   <= {data[W-2:0], 1'b0};
            cnt    <= CW'(W - 1);
            busy   <= 1'b1;
        end else if (busy && shift) begin
            // cnt counts bits still to present after the current one
            if (cnt != '0) begin
                serial <= sreg[W-1];
                sreg   <= {sreg[W-2:0], 1'b0};
                cnt    <= cnt - CW'(1);
            end else begin
                serial <= 1'b0;
                busy   <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/spi_slave.sv
// SPI slave: assembles 10-bit command frames for the RAM and serializes read data on MISO.
module spi_slave #(
    parameter int ADDR_SIZE = 8,
    parameter int FRAME_W   = spi_pkg::FRAME_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 SS_n,
    input  logic                 MOSI,
    output logic                 MISO,
    output logic [FRAME_W-1:0]   rx_data,
    output logic                 rx_valid,
    input  logic [ADDR_SIZE-1:0] tx_data,
    input  logic                 tx_valid
);
    import spi_pkg::*;

    state_t             state;
    logic [FRAME_W-2:0] shreg;
    logic [3:0]         cnt;
    logic               rd_addr_seen;
    logic               frame_done;
    logic               resp_started;
    logic               load;
    logic               shift_done;

    // Response window: read-data frame received, no response captured yet.
    assign load = (state == READ_DATA) && frame_done && !resp_started
                  && tx_valid && !SS_n && shift_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            shreg        <= '0;
            cnt          <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rd_addr_seen <= 1'b0;
            frame_done   <= 1'b0;
            resp_started <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (state != IDLE && SS_n) begin
                state        <= IDLE;
                cnt          <= '0;
                frame_done   <= 1'b0;
                resp_started <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        cnt          <= '0;
                        frame_done   <= 1'b0;
                        resp_started <= 1'b0;
                        if (!SS_n) state <= CHK_CMD;
                    end
                    CHK_CMD: begin
                        shreg <= {shreg[FRAME_W-3:0], MOSI};
                        cnt   <= '0;
                        if (!MOSI)             state <= WRITE;
                        else if (!rd_addr_seen) state <= READ_ADD;
                        else                    state <= READ_DATA;
                    end
                    default: begin
                        if (!frame_done) begin
                            shreg <= {shreg[FRAME_W-3:0], MOSI};
                            if (cnt == 4'(FRAME_W - 2)) begin
                                rx_data    <= {shreg, MOSI};
                                rx_valid   <= 1'b1;
                                frame_done <= 1'b1;
                                cnt        <= '0;
                                if (state == READ_ADD)       rd_addr_seen <= 1'b1;
                                else if (state == READ_DATA) rd_addr_seen <= 1'b0;
                            end else begin
                                cnt <= cnt + 4'd1;
                            end
                        end else if (load) begin
                            resp_started <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    spi_shift_out #(.W(ADDR_SIZE)) u_shift_out (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (SS_n),
        .load   (load),
        .shift  (state == READ_DATA),
        .data   (tx_data),
        .serial (MISO),
        .done   (shift_done)
    );

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: frame-level timeline model plus literal spot checks.
module tb_spi_slave;
    import spi_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       SS_n = 1'b1;
    logic       MOSI = 1'b0;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    logic       ram_vld = 1'b0;
    logic       stray = 1'b0;
    logic [7:0] rd_resp = 8'h00;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    bit         exp_rxv  [4096];
    logic [9:0] exp_rxd  [4096];
    bit         exp_miso [4096];
    bit         m_seen = 1'b0;

    logic [9:0]  last_rx = '0;
    int          last_rx_edge = -1;
    int          rx_count = 0;
    logic [15:0] miso_hist = '0;

    always #5 clk = ~clk;

    spi_slave dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    // RAM stand-in: answers a read-data command one cycle after rx_valid.
    assign tx_valid = ram_vld | stray;
    assign tx_data  = rd_resp;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        ram_vld <= rx_valid && (rx_data[9:8] == CMD_RD_DATA);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cyc > 0 && cyc < 4096) begin
            chk("rx_valid", 32'(rx_valid), 32'(exp_rxv[cyc]));
            chk("miso", 32'(MISO), 32'(exp_miso[cyc]));
            if (exp_rxv[cyc]) chk("rx_data", 32'(rx_data), 32'(exp_rxd[cyc]));
        end
        miso_hist = {miso_hist[14:0], MISO};
        if (rx_valid) begin
            last_rx      = rx_data;
            last_rx_edge = cyc;
            rx_count++;
        end
    end

    task automatic step(input logic ss, input logic mosi);
        SS_n = ss;
        MOSI = mosi;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1'b1, 1'b0);
        rst_n  = 1'b1;
        m_seen = 1'b0;
    endtask

    // Full frame, SS_n held low for 'hold' cycles after the last bit, then
    // released (optionally together with a one-cycle reset).
    task automatic frame(input logic [9:0] f, input int hold, input bit with_rst, output int e0);
        int  e_end;
        bit  rd;
        e0    = cyc + 1;
        e_end = e0 + 11 + hold;
        exp_rxv[e0+10] = 1'b1;
        exp_rxd[e0+10] = f;
        rd = 1'b0;
        if (f[9]) begin
            if (m_seen) begin
                rd     = 1'b1;
                m_seen = 1'b0;
            end else begin
                m_seen = 1'b1;
            end
        end
        if (rd)
            for (int i = 0; i < 8; i++)
                if (e0 + 12 + i < e_end) exp_miso[e0+12+i] = rd_resp[7-i];
        step(1'b0, 1'b0);
        for (int i = 9; i >= 0; i--) step(1'b0, f[i]);
        for (int i = 0; i < hold; i++) step(1'b0, 1'b0);
        if (with_rst) do_reset();
        else          step(1'b1, 1'b0);
    endtask

    int e0;
    int cnt_before;

    initial begin
        for (int i = 0; i < 4096; i++) begin
            exp_rxv[i]  = 1'b0;
            exp_rxd[i]  = '0;
            exp_miso[i] = 1'b0;
        end
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        rst_n = 1'b1;
        chk("reset_state", 32'(dut.state), 32'(IDLE));
        chk("reset_rx_data", 32'(rx_data), 32'h000);
        chk("reset_miso", 32'(MISO), 32'h0);
        chk("reset_seen", 32'(dut.rd_addr_seen), 32'h0);
        step(1'b1, 1'b0);

        // write address
        frame(10'h02A, 2, 1'b0, e0);
        chk("wr_addr_data", 32'(last_rx), 32'h02A);
        chk("wr_addr_latency", 32'(last_rx_edge - e0), 32'd10);
        chk("wr_addr_count", 32'(rx_count), 32'd1);

        // stray tx_valid outside a read window must not reach MISO
        stray = 1'b1;
        step(1'b1, 1'b0);
        stray = 1'b0;

        // write data
        frame(10'h15C, 3, 1'b0, e0);
        chk("wr_data_data", 32'(last_rx), 32'h15C);
        chk("wr_data_seen", 32'(dut.rd_addr_seen), 32'h0);

        // read address then read data with 0x5C response
        frame(10'h22A, 1, 1'b0, e0);
        chk("rd_addr_data", 32'(last_rx), 32'h22A);
        chk("rd_addr_seen", 32'(dut.rd_addr_seen), 32'h1);
        rd_resp = 8'h5C;
        frame(10'h300, 12, 1'b0, e0);
        chk("rd_data_data", 32'(last_rx), 32'h300);
        chk("rd_miso_bits", 32'(miso_hist[10:3]), 32'h5C);
        chk("rd_miso_tail", 32'({miso_hist[11], miso_hist[2:0]}), 32'h0);
        chk("rd_data_seen", 32'(dut.rd_addr_seen), 32'h0);

        // abort after 5 bits of a write frame
        cnt_before = rx_count;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        chk("abort_state", 32'(dut.state), 32'(IDLE));
        step(1'b1, 1'b0);
        chk("abort_no_rx", 32'(rx_count), 32'(cnt_before));
        frame(10'h011, 1, 1'b0, e0);
        chk("after_abort_data", 32'(last_rx), 32'h011);

        // reset during MISO shift-out
        frame(10'h2FF, 1, 1'b0, e0);
        rd_resp = 8'hA5;
        frame(10'h3C3, 5, 1'b1, e0);
        chk("rst_miso", 32'(MISO), 32'h0);
        chk("rst_rx_valid", 32'(rx_valid), 32'h0);
        chk("rst_seen", 32'(dut.rd_addr_seen), 32'h0);
        chk("rst_miso_bits", 32'(miso_hist[3:0]), 32'hA);

        // reset must forget a pending read address
        frame(10'h244, 1, 1'b0, e0);
        chk("seen_before_rst", 32'(dut.rd_addr_seen), 32'h1);
        do_reset();
        rd_resp = 8'h99;
        frame(10'h3AA, 12, 1'b0, e0);
        chk("post_rst_read_add", 32'(dut.rd_addr_seen), 32'h1);
        chk("post_rst_no_miso", 32'(miso_hist[10:3]), 32'h00);
        rd_resp = 8'hC3;
        frame(10'h355, 12, 1'b0, e0);
        chk("final_miso_bits", 32'(miso_hist[10:3]), 32'hC3);
        chk("final_seen", 32'(dut.rd_addr_seen), 32'h0);

        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
